unsigned_divider_restoring_16: RTL and testbench

Sequential radix-2 restoring divider: the inverse of the 16-bit unsigned multipliers. It takes a 2W-bit dividend, such as a multiplier product, and a W-bit divisor. It returns a 2W-bit quotient and a W-bit remainder, resolving one quotient bit per clock. It sits beside the multiplier datapath as the recovery and check path (product / A -> B) behind a valid/ready handshake on both sides.

---
 rtl/unsigned_divider_restoring_16.sv | 154 +++++++++++++++
 tb/tb_unsigned_divider_restoring_16.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/unsigned_divider_restoring_16.sv
// unsigned_divider_restoring_16
//   Sequential radix-2 restoring divider. Divides a 2*WIDTH-bit unsigned
//   dividend by a WIDTH-bit unsigned divisor, one quotient bit per clock,
//   MSB first. Used beside the multiplier datapath to recover an operand
//   from a product (product / A -> B).
//
// Ports
//   clk, rst_n           rising-edge clock, synchronous active-low reset
//   in_valid/in_ready    operand handshake (accepted only in IDLE)
//   dividend [2W-1:0]    unsigned dividend
//   divisor  [W-1:0]     unsigned divisor
//   out_valid/out_ready  result handshake (result held until accepted)
//   quotient [2W-1:0]    floor(dividend/divisor), all ones on divide-by-zero
//   remainder[W-1:0]     dividend mod divisor, 0 on divide-by-zero
//   div_by_zero          divisor was 0 for this result
//   q_overflow           quotient does not fit in W bits
module unsigned_divider_restoring_16 #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2*WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]     divisor,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   quotient,
    output logic [WIDTH-1:0]     remainder,
    output logic                 div_by_zero,
    output logic                 q_overflow
);

    localparam int DW = 2 * WIDTH;
    localparam int CW = $clog2(DW);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state_q, state_d;
    // Dividend bits shift out of the top while quotient bits shift in at
    // the bottom; after DW steps this register holds the quotient.
    logic [DW-1:0]     sh_q, sh_d;
    logic [WIDTH-1:0]  rem_q, rem_d;
    logic [WIDTH-1:0]  dvs_q, dvs_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              dz_q, dz_d;

    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic [DW-1:0]     quotient_q, quotient_d;
    logic [WIDTH-1:0]  remainder_q, remainder_d;
    logic              div_by_zero_q, div_by_zero_d;
    logic              q_overflow_q, q_overflow_d;

    // Trial value is WIDTH+1 bits so the shifted-out MSB takes part in the
    // compare. When trial >= divisor the true difference is below the
    // divisor and fits in WIDTH bits, so a WIDTH-bit subtract is exact.
    logic [WIDTH:0]    trial;
    logic              ge;

    always_comb begin
        trial = {rem_q, sh_q[DW-1]};
        ge    = (trial >= {1'b0, dvs_q});

        state_d       = state_q;
        sh_d          = sh_q;
        rem_d         = rem_q;
        dvs_d         = dvs_q;
        cnt_d         = cnt_q;
        dz_d          = dz_q;
        quotient_d    = quotient_q;
        remainder_d   = remainder_q;
        div_by_zero_d = div_by_zero_q;
        q_overflow_d  = q_overflow_q;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    dvs_d = divisor;
                    rem_d = '0;
                    cnt_d = '0;
                    dz_d  = (divisor == '0);
                    if (divisor == '0) begin
                        sh_d    = '1;
                        state_d = DONE;
                    end else begin
                        sh_d    = dividend;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                rem_d = ge ? (trial[WIDTH-1:0] - dvs_q) : trial[WIDTH-1:0];
                sh_d  = {sh_q[DW-2:0], ge};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(DW - 1)) state_d = DONE;
            end
            DONE: begin
                // First DONE cycle publishes the result; out_valid rises
                // on the same edge.
                if (!out_valid_q) begin
                    quotient_d    = sh_q;
                    remainder_d   = rem_q;
                    div_by_zero_d = dz_q;
                    q_overflow_d  = |sh_q[DW-1:WIDTH];
                end else if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_q == DONE) && (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            sh_q          <= '0;
            rem_q         <= '0;
            dvs_q         <= '0;
            cnt_q         <= '0;
            dz_q          <= 1'b0;
            in_ready_q    <= 1'b0;
            out_valid_q   <= 1'b0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            div_by_zero_q <= 1'b0;
            q_overflow_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            sh_q          <= sh_d;
            rem_q         <= rem_d;
            dvs_q         <= dvs_d;
            cnt_q         <= cnt_d;
            dz_q          <= dz_d;
            in_ready_q    <= in_ready_d;
            out_valid_q   <= out_valid_d;
            quotient_q    <= quotient_d;
            remainder_q   <= remainder_d;
            div_by_zero_q <= div_by_zero_d;
            q_overflow_q  <= q_overflow_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = div_by_zero_q;
    assign q_overflow  = q_overflow_q;

endmodule

// File: tb/tb_unsigned_divider_restoring_16.sv
// Testbench for unsigned_divider_restoring_16: table of directed divisions
// with hand-computed results, plus backpressure, mid-operation reset and
// input-isolation sequences.
module tb_unsigned_divider_restoring_16;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] dividend;
    logic [15:0] divisor;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;
    logic        q_overflow;

    int pass_cnt = 0;
    int total_cnt = 0;

    unsigned_divider_restoring_16 #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .dividend(dividend), .divisor(divisor),
        .out_valid(out_valid), .out_ready(out_ready),
        .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero), .q_overflow(q_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] dd;
        logic [15:0] dv;
        logic [31:0] q;
        logic [15:0] r;
        logic        dz;
        logic        ovf;
        int          lat;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        else
            pass_cnt++;
    endtask

    // Present operands and hold in_valid until the accept edge.
    task automatic accept(input logic [31:0] dd, input logic [15:0] dv);
        int g;
        g = 0;
        @(negedge clk);
        dividend = dd;
        divisor  = dv;
        in_valid = 1'b1;
        while (!in_ready && g < 100) begin
            @(negedge clk);
            g++;
        end
        chk("accept_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Returns number of edges after the accept edge until out_valid, -1 on timeout.
    task automatic wait_valid(input bit scramble, output int lat);
        lat = -1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = k;
                break;
            end
            if (scramble) begin
                dividend = $urandom;
                divisor  = 16'($urandom);
            end
            @(posedge clk);
        end
    endtask

    task automatic finish_op(input string tag, input int hold);
        logic [31:0] q0;
        logic [15:0] r0;
        q0 = quotient;
        r0 = remainder;
        chk({tag, "_no_in_ready"}, 64'(in_ready), 64'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("%s_hold%0d", tag, i),
                {14'd0, out_valid, in_ready, q0 ^ quotient, r0 ^ remainder},
                {14'd0, 1'b1, 1'b0, 32'd0, 16'd0});
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        chk({tag, "_in_ready_after"}, 64'(in_ready), 64'd1);
        chk({tag, "_out_valid_after"}, 64'(out_valid), 64'd0);
        chk({tag, "_q_held"}, 64'(quotient), 64'(q0));
    endtask

    task automatic run_vec(input string tag, input vec_t v, input bit scramble, input int hold);
        int lat;
        accept(v.dd, v.dv);
        wait_valid(scramble, lat);
        chk({tag, "_latency"}, 64'(lat), 64'(v.lat));
        chk({tag, "_quotient"}, 64'(quotient), 64'(v.q));
        chk({tag, "_remainder"}, 64'(remainder), 64'(v.r));
        chk({tag, "_div_by_zero"}, 64'(div_by_zero), 64'(v.dz));
        chk({tag, "_q_overflow"}, 64'(q_overflow), 64'(v.ovf));
        finish_op(tag, hold);
    endtask

    initial begin
        vec_t v;

        vecs[0] = '{32'd39812471,  16'd3943,   32'd10097,      16'd0,      1'b0, 1'b0, 33};
        vecs[1] = '{32'hFFFE_0001, 16'hFFFF,   32'h0000_FFFF,  16'd0,      1'b0, 1'b0, 33};
        vecs[2] = '{32'd100,       16'd7,      32'd14,         16'd2,      1'b0, 1'b0, 33};
        vecs[3] = '{32'hFFFF_FFFF, 16'd1,      32'hFFFF_FFFF,  16'd0,      1'b0, 1'b1, 33};
        vecs[4] = '{32'h1234_5678, 16'd0,      32'hFFFF_FFFF,  16'd0,      1'b1, 1'b1, 1};
        vecs[5] = '{32'hFFFF_FFFF, 16'hFFFF,   32'h0001_0001,  16'd0,      1'b0, 1'b1, 33};
        vecs[6] = '{32'h8000_0000, 16'hFFFF,   32'h0000_8000,  16'h8000,   1'b0, 1'b0, 33};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs",
            {10'd0, in_ready, out_valid, quotient, remainder, div_by_zero, q_overflow}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("ready_after_reset", 64'(in_ready), 64'd1);

        for (int i = 0; i < 7; i++)
            run_vec($sformatf("vec%0d", i), vecs[i], 1'b0, 0);

        // Backpressure: hold result 10 cycles, then a second operation.
        v = '{32'd50000, 16'd7, 32'd7142, 16'd6, 1'b0, 1'b0, 33};
        run_vec("bp_first", v, 1'b0, 10);
        v = '{32'd1000, 16'd3, 32'd333, 16'd1, 1'b0, 1'b0, 33};
        run_vec("bp_second", v, 1'b0, 0);

        // Reset in the middle of CALC.
        accept(32'd1000, 16'd3);
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midreset_outputs",
            {10'd0, in_ready, out_valid, quotient, remainder, div_by_zero, q_overflow}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midreset_ready", 64'(in_ready), 64'd1);
        v = '{32'd50, 16'd5, 32'd10, 16'd0, 1'b0, 1'b0, 33};
        run_vec("after_reset", v, 1'b0, 0);

        // Operands scrambled every cycle during CALC.
        v = '{32'd1000, 16'd3, 32'd333, 16'd1, 1'b0, 1'b0, 33};
        run_vec("isolation", v, 1'b1, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
